// File: rtl/mem_stage_if.sv
// mem_stage_if: single-master data bus between the memory stage and memory.
//
// Handshake: the master raises cyc with addr/wdata/sel/we valid and holds all
// of them stable until the slave answers with ack (transfer done, rdata valid
// in that same cycle) or err (transfer failed). cyc drops on the clock edge
// that consumes the answer. If both ack and err are high, err wins.
//
// Signals:
//   addr   master->slave  32  word-aligned byte address
//   wdata  master->slave  32  lane-steered write data
//   sel    master->slave   4  byte enables
//   we     master->slave   1  1 = write
//   cyc    master->slave   1  request valid
//   ack    slave->master   1  transfer complete
//   err    slave->master   1  transfer failed
//   rdata  slave->master  32  read data, valid with ack
interface mem_stage_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (output addr, wdata, sel, we, cyc, input ack, err, rdata);
    modport slave  (input addr, wdata, sel, we, cyc, output ack, err, rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage after ID/EX. Issues loads/stores on the data
// bus, aligns and extends load data, steers store lanes, detects misaligned
// accesses, bus errors and timeouts, and registers the MEM/WB bundle.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   ex_*                 EX-side controls (valid, flush, address, store data,
//                        mem flags, writeback source, we, waddr)
//   dbus                 data bus master (see mem_stage_if)
//   mem_stall            combinational hold for upstream stages
//   wb_*                 registered MEM/WB bundle and exception flags
//   dbg_state            1 while the FSM is in BUSY
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic               ex_flush,
    input  logic [31:0]        ex_alu_result,
    input  logic [31:0]        ex_store_data,
    input  logic [5:0]         ex_mem_flags,
    input  logic               ex_mem_ex_sel,
    input  logic               ex_we,
    input  logic [4:0]         ex_waddr,
    mem_stage_if.master        dbus,
    output logic               mem_stall,
    output logic [31:0]        wb_result,
    output logic               wb_we,
    output logic [4:0]         wb_waddr,
    output logic               wb_valid,
    output logic               wb_exc_load_misaligned,
    output logic               wb_exc_store_misaligned,
    output logic               wb_exc_load_fault,
    output logic               wb_exc_store_fault,
    output logic [31:0]        wb_badaddr,
    output logic               dbg_state
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             store_q;
    logic             mex_q;
    logic             we_q;
    logic [4:0]       waddr_q;
    logic             kill_q;

    // Flag bit 5 carries no meaning for this stage.
    logic unused_flag;
    assign unused_flag = ex_mem_flags[5];

    // ---------------- EX-side decode ----------------
    logic       is_load, is_store, access, misaligned;
    logic [1:0] size, off;
    logic [3:0] sel_c;
    logic [31:0] wdata_c;

    assign is_load  = ex_mem_flags[0];
    assign is_store = ex_mem_flags[1];
    assign size     = ex_mem_flags[3:2];
    assign off      = ex_alu_result[1:0];
    assign access   = ex_valid & ~ex_flush & (is_load | is_store);
    assign misaligned = ((size == 2'b01) & off[0]) | (size[1] & (off != 2'b00));

    always_comb begin
        sel_c   = 4'b1111;
        wdata_c = ex_store_data;
        case (size)
            2'b00: begin
                sel_c   = 4'b0001 << off;
                wdata_c = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                sel_c   = 4'b0011 << off;
                wdata_c = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // ---------------- Load extraction ----------------
    logic [31:0] rshift;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;

    assign rshift = dbus.rdata >> {addr_q[1:0], 3'b000};
    assign byte_v = rshift[7:0];
    assign half_v = addr_q[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];

    always_comb begin
        load_data = dbus.rdata;
        case (size_q)
            2'b00:   load_data = {{24{~uns_q & byte_v[7]}}, byte_v};
            2'b01:   load_data = {{16{~uns_q & half_v[15]}}, half_v};
            default: ;
        endcase
    end

    // ---------------- BUSY completion ----------------
    logic timeout, fault, done, kill_now;

    assign timeout  = (cnt_q == CNT_W'(TIMEOUT - 1));
    // ack beats timeout in the same cycle; err beats ack.
    assign fault    = dbus.err | (timeout & ~dbus.ack);
    assign done     = dbus.ack | fault;
    // A flush arriving in the completing cycle still kills the result.
    assign kill_now = kill_q | ex_flush;

    always_comb begin
        if (state == IDLE) mem_stall = access & ~misaligned;
        else               mem_stall = ~done;
    end

    assign dbus.addr = {addr_q[31:2], 2'b00};
    assign dbg_state = (state == BUSY);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state                   <= IDLE;
            cnt_q                   <= '0;
            addr_q                  <= '0;
            size_q                  <= '0;
            uns_q                   <= 1'b0;
            store_q                 <= 1'b0;
            mex_q                   <= 1'b0;
            we_q                    <= 1'b0;
            waddr_q                 <= '0;
            kill_q                  <= 1'b0;
            dbus.wdata              <= '0;
            dbus.sel                <= '0;
            dbus.we                 <= 1'b0;
            dbus.cyc                <= 1'b0;
            wb_result               <= '0;
            wb_we                   <= 1'b0;
            wb_waddr                <= '0;
            wb_valid                <= 1'b0;
            wb_exc_load_misaligned  <= 1'b0;
            wb_exc_store_misaligned <= 1'b0;
            wb_exc_load_fault       <= 1'b0;
            wb_exc_store_fault      <= 1'b0;
            wb_badaddr              <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access & ~misaligned) begin
                        state      <= BUSY;
                        cnt_q      <= '0;
                        kill_q     <= 1'b0;
                        addr_q     <= ex_alu_result;
                        size_q     <= size;
                        uns_q      <= ex_mem_flags[4];
                        store_q    <= is_store;
                        mex_q      <= ex_mem_ex_sel;
                        we_q       <= ex_we;
                        waddr_q    <= ex_waddr;
                        dbus.wdata <= wdata_c;
                        dbus.sel   <= sel_c;
                        dbus.we    <= is_store;
                        dbus.cyc   <= 1'b1;
                        // Bubble in MEM/WB while the access is pending.
                        wb_valid                <= 1'b0;
                        wb_we                   <= 1'b0;
                        wb_exc_load_misaligned  <= 1'b0;
                        wb_exc_store_misaligned <= 1'b0;
                        wb_exc_load_fault       <= 1'b0;
                        wb_exc_store_fault      <= 1'b0;
                        wb_badaddr              <= '0;
                    end else begin
                        wb_result               <= ex_alu_result;
                        wb_waddr                <= ex_waddr;
                        wb_valid                <= ex_valid & ~ex_flush;
                        wb_we                   <= ex_we & ex_valid & ~ex_flush
                                                   & ~(access & misaligned);
                        wb_exc_load_misaligned  <= access & misaligned & ~is_store;
                        wb_exc_store_misaligned <= access & misaligned & is_store;
                        wb_exc_load_fault       <= 1'b0;
                        wb_exc_store_fault      <= 1'b0;
                        wb_badaddr              <= (access & misaligned) ? ex_alu_result : '0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state                   <= IDLE;
                        dbus.cyc                <= 1'b0;
                        dbus.we                 <= 1'b0;
                        kill_q                  <= 1'b0;
                        wb_result               <= (mex_q & ~store_q & ~fault) ? load_data : addr_q;
                        wb_waddr                <= waddr_q;
                        wb_valid                <= ~kill_now;
                        wb_we                   <= we_q & ~store_q & ~fault & ~kill_now;
                        wb_exc_load_misaligned  <= 1'b0;
                        wb_exc_store_misaligned <= 1'b0;
                        wb_exc_load_fault       <= fault & ~store_q & ~kill_now;
                        wb_exc_store_fault      <= fault & store_q & ~kill_now;
                        wb_badaddr              <= (fault & ~kill_now) ? addr_q : '0;
                    end else begin
                        cnt_q    <= cnt_q + CNT_W'(1);
                        kill_q   <= kill_now;
                        wb_valid <= 1'b0;
                        wb_we    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_flush = 1'b0;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_store_data = '0;
    logic [5:0]  ex_mem_flags = '0;
    logic        ex_mem_ex_sel = 1'b0;
    logic        ex_we = 1'b0;
    logic [4:0]  ex_waddr = '0;
    logic        mem_stall;
    logic [31:0] wb_result;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic        wb_valid;
    logic        wb_exc_load_misaligned;
    logic        wb_exc_store_misaligned;
    logic        wb_exc_load_fault;
    logic        wb_exc_store_fault;
    logic [31:0] wb_badaddr;
    logic        dbg_state;

    mem_stage_if dbus ();

    mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .ex_valid                (ex_valid),
        .ex_flush                (ex_flush),
        .ex_alu_result           (ex_alu_result),
        .ex_store_data           (ex_store_data),
        .ex_mem_flags            (ex_mem_flags),
        .ex_mem_ex_sel           (ex_mem_ex_sel),
        .ex_we                   (ex_we),
        .ex_waddr                (ex_waddr),
        .dbus                    (dbus.master),
        .mem_stall               (mem_stall),
        .wb_result               (wb_result),
        .wb_we                   (wb_we),
        .wb_waddr                (wb_waddr),
        .wb_valid                (wb_valid),
        .wb_exc_load_misaligned  (wb_exc_load_misaligned),
        .wb_exc_store_misaligned (wb_exc_store_misaligned),
        .wb_exc_load_fault       (wb_exc_load_fault),
        .wb_exc_store_fault      (wb_exc_store_fault),
        .wb_badaddr              (wb_badaddr),
        .dbg_state               (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // first-BUSY-cycle snapshot of the bus request
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_sel;
    logic        cap_we;
    int          stall_n, busy_n;

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [5:0] flags, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic mex,
                           input logic we, input logic [4:0] waddr);
        ex_valid      = 1'b1;
        ex_flush      = 1'b0;
        ex_mem_flags  = flags;
        ex_alu_result = addr;
        ex_store_data = sdata;
        ex_mem_ex_sel = mex;
        ex_we         = we;
        ex_waddr      = waddr;
    endtask

    task automatic idle_ex();
        ex_valid      = 1'b0;
        ex_flush      = 1'b0;
        ex_mem_flags  = '0;
        ex_alu_result = '0;
        ex_store_data = '0;
        ex_mem_ex_sel = 1'b0;
        ex_we         = 1'b0;
        ex_waddr      = '0;
    endtask

    // Starts in the presentation cycle; answers on BUSY cycle ack_at/err_at
    // (0 = never). Returns after the completing edge with the bus quiet.
    task automatic run_access(input int ack_at, input int err_at, input logic [31:0] rdata,
                              output int stalls, output int busys);
        stalls = 0;
        busys  = 0;
        for (int i = 0; i < 40; i++) begin
            if (dbus.cyc) begin
                busys++;
                if (busys == 1) begin
                    cap_addr  = dbus.addr;
                    cap_wdata = dbus.wdata;
                    cap_sel   = dbus.sel;
                    cap_we    = dbus.we;
                end
            end
            dbus.ack   = dbus.cyc && (busys == ack_at);
            dbus.err   = dbus.cyc && (busys == err_at);
            dbus.rdata = rdata;
            #1;
            if (!mem_stall) break;
            stalls++;
            tick();
        end
        tick();
        dbus.ack   = 1'b0;
        dbus.err   = 1'b0;
        dbus.rdata = '0;
        idle_ex();
    endtask

    initial begin
        dbus.ack   = 1'b0;
        dbus.err   = 1'b0;
        dbus.rdata = '0;

        // reset
        rst = 1'b0;
        tick(); tick();
        check("rst_cyc", {31'b0, dbus.cyc}, 32'h0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        check("rst_wb_result", wb_result, 32'h0);
        check("rst_state", {31'b0, dbg_state}, 32'h0);
        rst = 1'b1;
        tick();

        // ALU op: visible one cycle later, no bus activity
        present(6'h00, 32'h0000_1234, 32'h0, 1'b0, 1'b1, 5'd5);
        #1;
        check("alu_stall", {31'b0, mem_stall}, 32'h0);
        tick();
        idle_ex();
        check("alu_result", wb_result, 32'h0000_1234);
        check("alu_we", {31'b0, wb_we}, 32'h1);
        check("alu_waddr", {27'b0, wb_waddr}, 32'd5);
        check("alu_valid", {31'b0, wb_valid}, 32'h1);
        check("alu_cyc", {31'b0, dbus.cyc}, 32'h0);
        tick();
        check("bubble_valid", {31'b0, wb_valid}, 32'h0);
        check("bubble_we", {31'b0, wb_we}, 32'h0);

        // signed byte load @0x103
        present(6'h01, 32'h0000_0103, 32'h0, 1'b1, 1'b1, 5'd7);
        run_access(1, 0, 32'h80FF_0000, stall_n, busy_n);
        check("lbs_addr", cap_addr, 32'h0000_0100);
        check("lbs_sel", {28'b0, cap_sel}, 32'h8);
        check("lbs_we", {31'b0, cap_we}, 32'h0);
        check("lbs_stall", stall_n, 32'd1);
        check("lbs_result", wb_result, 32'hFFFF_FF80);
        check("lbs_wb_we", {31'b0, wb_we}, 32'h1);
        check("lbs_waddr", {27'b0, wb_waddr}, 32'd7);
        check("lbs_cyc_off", {31'b0, dbus.cyc}, 32'h0);

        // unsigned byte load @0x103
        present(6'h11, 32'h0000_0103, 32'h0, 1'b1, 1'b1, 5'd8);
        run_access(1, 0, 32'h80FF_0000, stall_n, busy_n);
        check("lbu_result", wb_result, 32'h0000_0080);

        // signed half load @0x102
        present(6'h05, 32'h0000_0102, 32'h0, 1'b1, 1'b1, 5'd9);
        run_access(1, 0, 32'h8001_1234, stall_n, busy_n);
        check("lh_sel", {28'b0, cap_sel}, 32'hC);
        check("lh_result", wb_result, 32'hFFFF_8001);

        // word load, ack on second BUSY cycle
        present(6'h09, 32'h0000_0300, 32'h0, 1'b1, 1'b1, 5'd10);
        run_access(2, 0, 32'hDEAD_BEEF, stall_n, busy_n);
        check("lw_stall", stall_n, 32'd2);
        check("lw_result", wb_result, 32'hDEAD_BEEF);

        // half store @0x202
        present(6'h06, 32'h0000_0202, 32'hAAAA_BEEF, 1'b0, 1'b0, 5'd0);
        run_access(1, 0, 32'h0, stall_n, busy_n);
        check("sh_addr", cap_addr, 32'h0000_0200);
        check("sh_dbus_we", {31'b0, cap_we}, 32'h1);
        check("sh_sel", {28'b0, cap_sel}, 32'hC);
        check("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        check("sh_wb_we", {31'b0, wb_we}, 32'h0);
        check("sh_wb_valid", {31'b0, wb_valid}, 32'h1);

        // byte store lanes @0x101
        present(6'h02, 32'h0000_0101, 32'h1234_5678, 1'b0, 1'b0, 5'd0);
        run_access(1, 0, 32'h0, stall_n, busy_n);
        check("sb_sel", {28'b0, cap_sel}, 32'h2);
        check("sb_wdata", cap_wdata, 32'h7878_7878);

        // misaligned word load @0x301
        present(6'h09, 32'h0000_0301, 32'h0, 1'b1, 1'b1, 5'd3);
        #1;
        check("mis_stall", {31'b0, mem_stall}, 32'h0);
        tick();
        idle_ex();
        check("mis_cyc", {31'b0, dbus.cyc}, 32'h0);
        check("mis_exc", {31'b0, wb_exc_load_misaligned}, 32'h1);
        check("mis_badaddr", wb_badaddr, 32'h0000_0301);
        check("mis_wb_we", {31'b0, wb_we}, 32'h0);

        // timeout: no answer
        present(6'h09, 32'h0000_0400, 32'h0, 1'b1, 1'b1, 5'd4);
        run_access(0, 0, 32'h0, stall_n, busy_n);
        check("to_stall", stall_n, 32'd16);
        check("to_busy", busy_n, 32'd16);
        check("to_fault", {31'b0, wb_exc_load_fault}, 32'h1);
        check("to_badaddr", wb_badaddr, 32'h0000_0400);
        check("to_wb_we", {31'b0, wb_we}, 32'h0);

        // err on BUSY cycle 3, together with ack (err wins)
        present(6'h09, 32'h0000_0500, 32'h0, 1'b1, 1'b1, 5'd4);
        run_access(3, 3, 32'h0, stall_n, busy_n);
        check("err_busy", busy_n, 32'd3);
        check("err_fault", {31'b0, wb_exc_load_fault}, 32'h1);
        check("err_wb_we", {31'b0, wb_we}, 32'h0);

        // store fault via err
        present(6'h0A, 32'h0000_0600, 32'h1, 1'b0, 1'b0, 5'd0);
        run_access(0, 1, 32'h0, stall_n, busy_n);
        check("sf_fault", {31'b0, wb_exc_store_fault}, 32'h1);
        check("sf_badaddr", wb_badaddr, 32'h0000_0600);

        // flush during BUSY, ack afterwards
        present(6'h09, 32'h0000_0700, 32'h0, 1'b1, 1'b1, 5'd6);
        tick();
        check("fl_cyc", {31'b0, dbus.cyc}, 32'h1);
        ex_flush = 1'b1;
        tick();
        ex_flush   = 1'b0;
        dbus.ack   = 1'b1;
        dbus.rdata = 32'h1111_2222;
        tick();
        dbus.ack = 1'b0;
        idle_ex();
        check("fl_valid", {31'b0, wb_valid}, 32'h0);
        check("fl_we", {31'b0, wb_we}, 32'h0);
        check("fl_cyc_off", {31'b0, dbus.cyc}, 32'h0);

        // reset mid-BUSY
        present(6'h09, 32'h0000_0800, 32'h0, 1'b1, 1'b1, 5'd2);
        tick();
        check("mr_cyc_on", {31'b0, dbus.cyc}, 32'h1);
        rst = 1'b0;
        tick();
        check("mr_cyc_off", {31'b0, dbus.cyc}, 32'h0);
        check("mr_state", {31'b0, dbg_state}, 32'h0);
        check("mr_wb_valid", {31'b0, wb_valid}, 32'h0);
        check("mr_wb_result", wb_result, 32'h0);
        rst = 1'b1;
        idle_ex();
        tick();

        // recovery after reset: plain ALU op
        present(6'h00, 32'hCAFE_0001, 32'h0, 1'b0, 1'b1, 5'd31);
        tick();
        idle_ex();
        check("post_result", wb_result, 32'hCAFE_0001);
        check("post_waddr", {27'b0, wb_waddr}, 32'd31);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
